// File: rtl/i2c_target_regs.sv
// I2C target with a byte-wide register access port: filtered SCL/SDA, bus
// event detection, byte FSM, auto-incrementing register pointer.
module i2c_target_regs #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         FILT_LEN    = 3,
    parameter int         HOLD_CYC    = 4
) (
    input  logic       I_clk,
    input  logic       I_rst,
    input  logic       I_scl,
    input  logic       I_sda,
    output logic       O_sda_oe,
    output logic       O_busy,
    output logic       O_wr_stb,
    output logic [7:0] O_wr_addr,
    output logic [7:0] O_wr_data,
    output logic [7:0] O_rd_addr,
    input  logic [7:0] I_rd_data
);

    // state      | meaning
    // IDLE       | bus free or after STOP
    // ADDR       | shifting in address + R/W byte
    // ADDR_ACK   | driving ACK for our address
    // IGNORE     | not addressed / read NACKed, wait for START or STOP
    // WR_PTR     | shifting in register pointer byte
    // WR_PTR_ACK | driving ACK for pointer byte
    // WR_DATA    | shifting in write data byte
    // WR_ACK     | driving ACK for write data byte
    // RD_DATA    | shifting out read data byte
    // RD_MACK    | controller ACK/NACK slot after a read byte

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, IGNORE, WR_PTR, WR_PTR_ACK,
        WR_DATA, WR_ACK, RD_DATA, RD_MACK
    } state_t;

    localparam int           HW      = $clog2(HOLD_CYC + 1);
    localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYC);
    localparam logic [HW-1:0] HOLD_TC = HW'(1);
    localparam logic [3:0]   FILT_LD = 4'(FILT_LEN - 1);

    logic       scl_s1, scl_s2, sda_s1, sda_s2;
    logic [3:0] scl_cnt, sda_cnt;
    logic       scl_f, sda_f, scl_q, sda_q;
    logic       scl_rise, scl_fall, start_ev, stop_ev;

    state_t     state, state_nxt;
    logic [3:0] bit_cnt;
    logic [6:0] shreg;
    logic [7:0] rx_byte;
    logic [7:0] ptr;
    logic       rw;
    logic       sda_pend, pend_nxt;
    logic [HW-1:0] hold_cnt;

    logic clr_bits, cnt_en, rx_shift, rd_load, rd_shift;
    logic set_busy, clr_busy, latch_rw, load_ptr, wr_fire, rd_inc;
    logic last_bit;

    // Synchronizers and counter filters; a level change needs FILT_LEN
    // consecutive differing samples, so shorter glitches never reach the FSM.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            scl_s1  <= 1'b1;
            scl_s2  <= 1'b1;
            sda_s1  <= 1'b1;
            sda_s2  <= 1'b1;
            scl_f   <= 1'b1;
            sda_f   <= 1'b1;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
            scl_cnt <= FILT_LD;
            sda_cnt <= FILT_LD;
        end else begin
            scl_s1 <= I_scl;
            scl_s2 <= scl_s1;
            sda_s1 <= I_sda;
            sda_s2 <= sda_s1;
            scl_q  <= scl_f;
            sda_q  <= sda_f;
            if (scl_s2 == scl_f) begin
                scl_cnt <= FILT_LD;
            end else if (scl_cnt == 4'd0) begin
                scl_f   <= scl_s2;
                scl_cnt <= FILT_LD;
            end else begin
                scl_cnt <= scl_cnt - 4'd1;
            end
            if (sda_s2 == sda_f) begin
                sda_cnt <= FILT_LD;
            end else if (sda_cnt == 4'd0) begin
                sda_f   <= sda_s2;
                sda_cnt <= FILT_LD;
            end else begin
                sda_cnt <= sda_cnt - 4'd1;
            end
        end
    end

    assign scl_rise = scl_f & ~scl_q;
    assign scl_fall = ~scl_f & scl_q;
    assign start_ev = ~sda_f & sda_q & scl_f;
    assign stop_ev  = sda_f & ~sda_q & scl_f;
    assign last_bit = (bit_cnt == 4'd7);
    assign rx_byte  = {shreg, sda_f};

    always_comb begin
        state_nxt = state;
        pend_nxt  = sda_pend;
        clr_bits  = 1'b0;
        cnt_en    = 1'b0;
        rx_shift  = 1'b0;
        rd_load   = 1'b0;
        rd_shift  = 1'b0;
        set_busy  = 1'b0;
        clr_busy  = 1'b0;
        latch_rw  = 1'b0;
        load_ptr  = 1'b0;
        wr_fire   = 1'b0;
        rd_inc    = 1'b0;
        if (start_ev) begin
            state_nxt = ADDR;
            clr_bits  = 1'b1;
            pend_nxt  = 1'b0;
        end else if (stop_ev) begin
            state_nxt = IDLE;
            clr_busy  = 1'b1;
            pend_nxt  = 1'b0;
        end else begin
            // Any SCL fall releases SDA unless the state below says otherwise.
            if (scl_fall) pend_nxt = 1'b0;
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        cnt_en   = 1'b1;
                        rx_shift = 1'b1;
                        if (last_bit) begin
                            if (shreg == TARGET_ADDR) begin
                                state_nxt = ADDR_ACK;
                                set_busy  = 1'b1;
                                latch_rw  = 1'b1;
                            end else begin
                                state_nxt = IGNORE;
                                clr_busy  = 1'b1;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) pend_nxt = 1'b1;
                    if (scl_rise) begin
                        state_nxt = rw ? RD_DATA : WR_PTR;
                        clr_bits  = 1'b1;
                    end
                end
                WR_PTR: begin
                    if (scl_rise) begin
                        cnt_en   = 1'b1;
                        rx_shift = 1'b1;
                        if (last_bit) begin
                            state_nxt = WR_PTR_ACK;
                            load_ptr  = 1'b1;
                        end
                    end
                end
                WR_PTR_ACK, WR_ACK: begin
                    if (scl_fall) pend_nxt = 1'b1;
                    if (scl_rise) begin
                        state_nxt = WR_DATA;
                        clr_bits  = 1'b1;
                    end
                end
                WR_DATA: begin
                    if (scl_rise) begin
                        cnt_en   = 1'b1;
                        rx_shift = 1'b1;
                        if (last_bit) begin
                            state_nxt = WR_ACK;
                            wr_fire   = 1'b1;
                        end
                    end
                end
                RD_DATA: begin
                    // MSB goes straight from I_rd_data; the rest from shreg.
                    if (scl_fall) begin
                        if (bit_cnt == 4'd0) begin
                            rd_load  = 1'b1;
                            pend_nxt = ~I_rd_data[7];
                        end else begin
                            rd_shift = 1'b1;
                            pend_nxt = ~shreg[6];
                        end
                    end
                    if (scl_rise) begin
                        cnt_en = 1'b1;
                        if (last_bit) begin
                            state_nxt = RD_MACK;
                            rd_inc    = 1'b1;
                        end
                    end
                end
                RD_MACK: begin
                    if (scl_rise) begin
                        state_nxt = sda_f ? IGNORE : RD_DATA;
                        clr_bits  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            shreg     <= 7'd0;
            ptr       <= 8'd0;
            rw        <= 1'b0;
            sda_pend  <= 1'b0;
            hold_cnt  <= '0;
            O_sda_oe  <= 1'b0;
            O_busy    <= 1'b0;
            O_wr_stb  <= 1'b0;
            O_wr_addr <= 8'd0;
            O_wr_data <= 8'd0;
        end else begin
            state    <= state_nxt;
            sda_pend <= pend_nxt;
            O_wr_stb <= wr_fire;

            if (clr_bits) bit_cnt <= 4'd0;
            else if (cnt_en) bit_cnt <= bit_cnt + 4'd1;

            if (rd_load) shreg <= I_rd_data[6:0];
            else if (rd_shift) shreg <= {shreg[5:0], 1'b0};
            else if (rx_shift) shreg <= rx_byte[6:0];

            if (latch_rw) rw <= sda_f;

            if (set_busy) O_busy <= 1'b1;
            else if (clr_busy) O_busy <= 1'b0;

            if (wr_fire) begin
                O_wr_addr <= ptr;
                O_wr_data <= rx_byte;
            end

            if (load_ptr) ptr <= rx_byte;
            else if (O_wr_stb || rd_inc) ptr <= ptr + 8'd1;

            // SDA only changes HOLD_CYC clocks after a filtered SCL fall.
            if (start_ev || stop_ev) begin
                hold_cnt <= '0;
                O_sda_oe <= 1'b0;
            end else if (scl_fall) begin
                hold_cnt <= HOLD_LD;
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HOLD_TC;
                if (hold_cnt == HOLD_TC) O_sda_oe <= sda_pend;
            end
        end
    end

    assign O_rd_addr = ptr;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: bit-banged I2C controller on a
// wired-AND SDA, with register read data modelled as address ^ 0xFF.
module tb_i2c_target_regs;

    localparam int Q = 12;

    logic       I_clk = 1'b0;
    logic       I_rst;
    logic       I_scl;
    logic       I_sda;
    logic       O_sda_oe;
    logic       O_busy;
    logic       O_wr_stb;
    logic [7:0] O_wr_addr;
    logic [7:0] O_wr_data;
    logic [7:0] O_rd_addr;
    logic [7:0] I_rd_data;

    logic scl_c = 1'b1;
    logic sda_c = 1'b1;

    int n_chk  = 0;
    int n_pass = 0;

    logic       mon_clr = 1'b0;
    logic [7:0] stb_a [16];
    logic [7:0] stb_d [16];
    int         stb_n = 0;
    logic       oe_seen = 1'b0;
    logic       busy_seen = 1'b0;

    always #5 I_clk = ~I_clk;

    assign I_scl     = scl_c;
    assign I_sda     = sda_c & ~O_sda_oe;
    assign I_rd_data = O_rd_addr ^ 8'hFF;

    i2c_target_regs dut (
        .I_clk     (I_clk),
        .I_rst     (I_rst),
        .I_scl     (I_scl),
        .I_sda     (I_sda),
        .O_sda_oe  (O_sda_oe),
        .O_busy    (O_busy),
        .O_wr_stb  (O_wr_stb),
        .O_wr_addr (O_wr_addr),
        .O_wr_data (O_wr_data),
        .O_rd_addr (O_rd_addr),
        .I_rd_data (I_rd_data)
    );

    always @(negedge I_clk) begin
        if (mon_clr) begin
            stb_n     <= 0;
            oe_seen   <= 1'b0;
            busy_seen <= 1'b0;
        end else begin
            if (O_wr_stb && stb_n < 16) begin
                stb_a[stb_n] <= O_wr_addr;
                stb_d[stb_n] <= O_wr_data;
                stb_n        <= stb_n + 1;
            end
            if (O_sda_oe) oe_seen <= 1'b1;
            if (O_busy) busy_seen <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge I_clk);
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        wait_cyc(1);
        mon_clr = 1'b0;
    endtask

    task automatic bus_start();
        sda_c = 1'b1;
        wait_cyc(Q);
        scl_c = 1'b1;
        wait_cyc(Q);
        sda_c = 1'b0;
        wait_cyc(Q);
        scl_c = 1'b0;
        wait_cyc(Q);
    endtask

    task automatic bus_stop();
        sda_c = 1'b0;
        wait_cyc(Q);
        scl_c = 1'b1;
        wait_cyc(Q);
        sda_c = 1'b1;
        wait_cyc(2 * Q);
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        sda_c = b;
        wait_cyc(Q);
        scl_c = 1'b1;
        if (glitch) begin
            wait_cyc(Q - 4);
            scl_c = 1'b0;
            wait_cyc(2);
            scl_c = 1'b1;
            wait_cyc(Q + 2);
        end else begin
            wait_cyc(2 * Q);
        end
        scl_c = 1'b0;
        wait_cyc(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_c = 1'b1;
        wait_cyc(Q);
        scl_c = 1'b1;
        wait_cyc(Q);
        b = I_sda;
        wait_cyc(Q);
        scl_c = 1'b0;
        wait_cyc(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i], i == glitch_bit);
        recv_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic mack);
        logic b;
        d = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(mack, 1'b0);
    endtask

    initial begin
        wait_cyc(60000);
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       ack;
        logic [7:0] d;
        logic       hit;

        I_rst = 1'b1;
        wait_cyc(5);
        check("rst_sda_oe", O_sda_oe, 0);
        check("rst_busy", O_busy, 0);
        check("rst_wr_stb", O_wr_stb, 0);
        check("rst_wr_addr", O_wr_addr, 0);
        check("rst_wr_data", O_wr_data, 0);
        check("rst_rd_addr", O_rd_addr, 0);
        I_rst = 1'b0;
        wait_cyc(20);

        // write burst
        clear_mon();
        bus_start();
        send_byte(8'hA0, -1, ack);  check("wb_ack_addr", ack, 0);
        check("wb_busy", O_busy, 1);
        send_byte(8'h10, -1, ack);  check("wb_ack_ptr", ack, 0);
        send_byte(8'h5A, -1, ack);  check("wb_ack_d0", ack, 0);
        send_byte(8'hC3, -1, ack);  check("wb_ack_d1", ack, 0);
        bus_stop();
        check("wb_stb_n", stb_n, 2);
        check("wb_stb0_addr", stb_a[0], 8'h10);
        check("wb_stb0_data", stb_d[0], 8'h5A);
        check("wb_stb1_addr", stb_a[1], 8'h11);
        check("wb_stb1_data", stb_d[1], 8'hC3);
        check("wb_rd_addr", O_rd_addr, 8'h12);
        check("wb_busy_end", O_busy, 0);

        // pointer set, repeated start, two-byte read
        clear_mon();
        bus_start();
        send_byte(8'hA0, -1, ack);  check("rd_ack_addr", ack, 0);
        send_byte(8'h20, -1, ack);  check("rd_ack_ptr", ack, 0);
        bus_start();
        send_byte(8'hA1, -1, ack);  check("rd_ack_addr_r", ack, 0);
        recv_byte(d, 1'b0);         check("rd_byte0", d, 8'hDF);
        recv_byte(d, 1'b1);         check("rd_byte1", d, 8'hDE);
        check("rd_sda_after_nack", O_sda_oe, 0);
        bus_stop();
        check("rd_rd_addr", O_rd_addr, 8'h22);
        check("rd_stb_n", stb_n, 0);
        check("rd_busy_end", O_busy, 0);

        // address mismatch
        clear_mon();
        bus_start();
        send_byte(8'hA2, -1, ack);  check("mm_nack_addr", ack, 1);
        send_byte(8'h00, -1, ack);  check("mm_nack_data", ack, 1);
        bus_stop();
        check("mm_oe_seen", oe_seen, 0);
        check("mm_stb_n", stb_n, 0);
        check("mm_busy_seen", busy_seen, 0);
        check("mm_rd_addr", O_rd_addr, 8'h22);

        // pointer wrap
        clear_mon();
        bus_start();
        send_byte(8'hA0, -1, ack);
        send_byte(8'hFF, -1, ack);
        send_byte(8'h11, -1, ack);  check("wr_ack_d0", ack, 0);
        send_byte(8'h22, -1, ack);  check("wr_ack_d1", ack, 0);
        bus_stop();
        check("wr_stb_n", stb_n, 2);
        check("wr_stb0_addr", stb_a[0], 8'hFF);
        check("wr_stb0_data", stb_d[0], 8'h11);
        check("wr_stb1_addr", stb_a[1], 8'h00);
        check("wr_stb1_data", stb_d[1], 8'h22);
        check("wr_rd_addr", O_rd_addr, 8'h01);

        // SCL glitch inside a byte, then STOP after 5 bits of the next byte
        clear_mon();
        bus_start();
        send_byte(8'hA0, -1, ack);
        send_byte(8'h40, -1, ack);
        send_byte(8'h96, 3, ack);   check("gl_ack", ack, 0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        bus_stop();
        check("gl_stb_n", stb_n, 1);
        check("gl_stb0_addr", stb_a[0], 8'h40);
        check("gl_stb0_data", stb_d[0], 8'h96);
        check("ab_rd_addr", O_rd_addr, 8'h41);
        check("ab_busy", O_busy, 0);

        // reset while driving a read bit low (0x30 ^ 0xFF = 0xCF, bit 5 is 0)
        clear_mon();
        bus_start();
        send_byte(8'hA0, -1, ack);
        send_byte(8'h30, -1, ack);
        bus_start();
        send_byte(8'hA1, -1, ack);
        recv_bit(hit);
        recv_bit(hit);
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (O_sda_oe) begin
                hit = 1'b1;
                break;
            end
            wait_cyc(1);
        end
        check("rs_oe_before", hit, 1);
        I_rst = 1'b1;
        wait_cyc(1);
        check("rs_sda_oe", O_sda_oe, 0);
        check("rs_rd_addr", O_rd_addr, 0);
        check("rs_busy", O_busy, 0);
        scl_c = 1'b1;
        sda_c = 1'b1;
        wait_cyc(4);
        I_rst = 1'b0;
        wait_cyc(30);
        clear_mon();
        bus_start();
        send_byte(8'hA0, -1, ack);  check("rs_ack_addr", ack, 0);
        send_byte(8'h05, -1, ack);  check("rs_ack_ptr", ack, 0);
        send_byte(8'h77, -1, ack);  check("rs_ack_d0", ack, 0);
        bus_stop();
        check("rs_stb_n", stb_n, 1);
        check("rs_stb0_addr", stb_a[0], 8'h05);
        check("rs_stb0_data", stb_d[0], 8'h77);
        check("rs_rd_addr_end", O_rd_addr, 8'h06);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
- I2C target (responder) with byte-wide register access port into fabric logic.
- Lets an external I2C controller, such as the soft MCU's I2C master on the board, read and write FPGA status/control registers.
- Sits on an open-drain SCL/SDA pair. The pad-level tristate lives outside this block; SDA is driven low only when O_sda_oe=1.
- Single clock domain. SCL/SDA are asynchronous inputs, oversampled and filtered internally.

Parameters:
- TARGET_ADDR, 7'h50, 7-bit I2C address this block responds to.
- FILT_LEN, 3, consecutive equal samples required before the filtered SCL/SDA level changes (range 1..15).
- HOLD_CYC, 4, I_clk cycles after a filtered SCL fall before O_sda_oe may change (SDA data hold). Must be < SCL low time in clocks.

Ports:
- I_clk  input  1  system clock (25 MHz nominal; must be ≥ 16× SCL rate).
- I_rst  input  1  synchronous active-high reset.
- I_scl  input  1  raw SCL pad level, asynchronous.
- I_sda  input  1  raw SDA pad level, asynchronous.
- O_sda_oe  output  1  1 = pull SDA low; 0 = release.
- O_busy  output  1  high from address match until STOP, or until a START not addressed to us.
- O_wr_stb  output  1  one-cycle write strobe.
- O_wr_addr  output  8  register address for the write, valid with O_wr_stb.
- O_wr_data  output  8  write data, valid with O_wr_stb.
- O_rd_addr  output  8  register address of the next read byte; held stable.
- I_rd_data  input  8  read data for O_rd_addr, sampled as defined below.

Behaviour:
- Reset values:
  - O_sda_oe=0, O_busy=0, O_wr_stb=0, O_wr_addr=0, O_wr_data=0.
  - Register pointer=0, so O_rd_addr=0.
  - State=IDLE; filter outputs=1.
- Input conditioning:
  - 2-FF synchronizer per line, then a FILT_LEN counter filter.
  - Edge detect on the filtered signals; all protocol decisions use filtered levels only.
- Bus events:
  - START = filtered SDA fall while filtered SCL=1.
  - STOP = filtered SDA rise while filtered SCL=1.
  - Data bits are sampled on the filtered SCL rise.
- Events override state:
  - START from any state → ADDR, bit counter cleared. Repeated START is included.
  - STOP from any state → IDLE, O_sda_oe=0, O_busy=0.
- States: IDLE, ADDR, ADDR_ACK, IGNORE, WR_PTR, WR_PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_MACK.
- ADDR:
  - Shifts 8 bits MSB-first.
  - On the 8th SCL rise: if bits[7:1]==TARGET_ADDR → ADDR_ACK, O_busy=1, R/W latched. Otherwise → IGNORE.
- IGNORE:
  - O_sda_oe held 0.
  - Wait for START or STOP.
- Every ACK slot (ADDR_ACK, WR_PTR_ACK, WR_ACK):
  - O_sda_oe=1, HOLD_CYC cycles after the SCL fall that ends bit 8.
  - O_sda_oe released HOLD_CYC cycles after the SCL fall that ends the ACK bit.
- After ADDR_ACK: → WR_PTR if R/W=0, → RD_DATA if R/W=1.
- WR_PTR:
  - On the 8th bit, pointer ← byte.
  - Then WR_PTR_ACK → WR_DATA.
- WR_DATA:
  - On the 8th bit (cycle after the detected SCL rise): O_wr_stb=1 for one cycle, with O_wr_addr=pointer and O_wr_data=byte.
  - Pointer increments mod 256 (0xFF→0x00) on the cycle after the strobe.
  - Then WR_ACK → WR_DATA.
  - Every written byte is ACKed; no NACK on write.
- RD_DATA:
  - I_rd_data is captured into the shift register on the SCL fall ending the previous ACK. O_rd_addr is stable ≥ HOLD_CYC cycles before this capture.
  - Each bit is driven (O_sda_oe = ~bit) HOLD_CYC cycles after each SCL fall.
  - After bit 8, SDA is released → RD_MACK.
- RD_MACK:
  - Pointer increments mod 256 at entry.
  - Controller bit sampled on SCL rise: 0 (ACK) → RD_DATA next byte; 1 (NACK) → IGNORE, SDA released.
- STOP or START mid-byte: the partial byte is discarded, no strobe, pointer unchanged for that byte.
- Pointer persists across transactions until reset.
- I_rst mid-transfer: all outputs return to reset values on the next clock edge; SDA is released immediately.

Test Plan:
- Write burst: START, 0xA0, 0x10, 0x5A, 0xC3, STOP → 4 ACKs; O_wr_stb ×2 with (0x10,0x5A) then (0x11,0xC3); O_rd_addr=0x12; O_busy falls at STOP.
- Read with repeated START: START, 0xA0, 0x20, Sr, 0xA1; bench model returns rd_data = addr^0xFF; controller ACKs then NACKs → bytes 0xDF, 0xDE on SDA; SDA released after the NACK; O_rd_addr=0x22.
- Address mismatch: START, 0xA2, 0x00, STOP → O_sda_oe=0 throughout, no O_wr_stb, O_busy stays 0.
- Wrap: pointer 0xFF, write 0x11, 0x22 → strobes at addresses 0xFF then 0x00; pointer ends at 0x01.
- Glitch and abort: 2-cycle low pulse on SCL mid-byte (FILT_LEN=3) → no extra bit counted, byte correct. STOP after bit 5 of a data byte → no strobe, state IDLE.
- Reset during a read bit with O_sda_oe=1 → O_sda_oe=0 the next cycle, pointer 0; the next transaction completes correctly.
